// File: rtl/sram_stream_adapter.sv
// Adapts a valid/ready request stream onto a single-port SRAM with fixed read
// latency, buffering read data in a credit-protected response FIFO.
module sram_stream_adapter #(
    parameter int NumWords  = 1024,
    parameter int DataWidth = 64,
    parameter int ByteWidth = 8,
    parameter int Latency   = 1,
    parameter int RspDepth  = 2,
    localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i
);

    localparam int CntWidth = $clog2(RspDepth + 1);
    localparam int PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    logic [Latency-1:0]   stage_vld;
    logic [CntWidth-1:0]  inflight;
    logic [CntWidth-1:0]  fifo_count;
    logic [CntWidth-1:0]  credits;
    logic [PtrWidth-1:0]  wr_ptr;
    logic [PtrWidth-1:0]  rd_ptr;
    logic [DataWidth-1:0] fifo_mem [RspDepth];
    logic                 req_fire;
    logic                 rd_fire;
    logic                 push;
    logic                 pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < Latency; i++) begin
            inflight = inflight + CntWidth'(stage_vld[i]);
        end
    end

    // Every outstanding read owns a FIFO slot from acceptance until its pop;
    // a slot freed by a pop only shows up once fifo_count has updated.
    assign credits     = CntWidth'(RspDepth) - inflight - fifo_count;
    assign req_ready_o = req_we_i | (credits != '0);
    assign req_fire    = req_valid_i & req_ready_o;
    assign rd_fire     = req_fire & ~req_we_i;

    assign sram_req_o   = req_fire;
    assign sram_we_o    = req_we_i;
    assign sram_addr_o  = req_addr_i;
    assign sram_wdata_o = req_wdata_i;
    assign sram_be_o    = req_be_i;

    assign push        = stage_vld[Latency-1];
    assign pop         = rsp_valid_o & rsp_ready_i;
    assign rsp_valid_o = (fifo_count != '0);
    assign rsp_rdata_o = fifo_mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_vld <= '0;
        end else begin
            stage_vld[0] <= rd_fire;
            for (int i = 1; i < Latency; i++) begin
                stage_vld[i] <= stage_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PtrWidth'(RspDepth - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PtrWidth'(RspDepth - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage carries no reset: validity is tracked entirely by fifo_count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= sram_rdata_i;
        end
    end

    push_into_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && !pop && (fifo_count == CntWidth'(RspDepth))));

endmodule

// File: tb/tb_sram_stream_adapter.sv
// Randomized and directed bench for sram_stream_adapter: two instances
// (depth 2 and depth 3, latency 2) checked against a response-queue model.
module tb_sram_stream_adapter;

    localparam int Lat = 2;

    typedef struct {
        logic [31:0] data;
        int          avail;
    } rsp_t;

    bit clk;
    int cyc;
    int n_checks;
    int n_pass;
    int b_pops;

    logic        rst_a_n, rst_b_n;
    logic        a_req_valid, a_req_ready, a_req_we;
    logic [3:0]  a_req_addr, a_req_be, a_sram_addr, a_sram_be;
    logic [31:0] a_req_wdata, a_rsp_rdata, a_sram_wdata, a_sram_rdata;
    logic        a_rsp_valid, a_rsp_ready, a_sram_req, a_sram_we;
    logic        b_req_valid, b_req_ready, b_req_we;
    logic [3:0]  b_req_addr, b_req_be, b_sram_addr, b_sram_be;
    logic [31:0] b_req_wdata, b_rsp_rdata, b_sram_wdata, b_sram_rdata;
    logic        b_rsp_valid, b_rsp_ready, b_sram_req, b_sram_we;

    rsp_t q_a[$];
    rsp_t q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_stream_adapter #(.NumWords(16), .DataWidth(32), .ByteWidth(8),
                          .Latency(Lat), .RspDepth(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_a_n),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_req_we),
        .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata), .req_be_i(a_req_be),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_rdata_o(a_rsp_rdata),
        .sram_req_o(a_sram_req), .sram_we_o(a_sram_we), .sram_addr_o(a_sram_addr),
        .sram_wdata_o(a_sram_wdata), .sram_be_o(a_sram_be), .sram_rdata_i(a_sram_rdata)
    );

    sram_stream_adapter #(.NumWords(16), .DataWidth(32), .ByteWidth(8),
                          .Latency(Lat), .RspDepth(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_b_n),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
        .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata), .req_be_i(b_req_be),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata),
        .sram_req_o(b_sram_req), .sram_we_o(b_sram_we), .sram_addr_o(b_sram_addr),
        .sram_wdata_o(b_sram_wdata), .sram_be_o(b_sram_be), .sram_rdata_i(b_sram_rdata)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // SRAM model for instance A: unwritten words read as A5A5_00xx, two-cycle read pipe.
    bit   [31:0] sram_mem [16];
    bit          sram_wr  [16];
    logic [31:0] a_pipe0, a_pipe1, b_pipe0, b_pipe1;
    assign a_sram_rdata = a_pipe1;
    assign b_sram_rdata = b_pipe1;

    always @(posedge clk) begin
        logic [31:0] cur;
        cur = sram_wr[a_sram_addr] ? sram_mem[a_sram_addr] : (32'hA5A5_0000 | 32'(a_sram_addr));
        a_pipe0 <= 32'hDEAD_BEEF;
        if (a_sram_req && a_sram_we) begin
            for (int k = 0; k < 4; k++)
                if (a_sram_be[k]) cur[8*k +: 8] = a_sram_wdata[8*k +: 8];
            sram_mem[a_sram_addr] <= cur;
            sram_wr[a_sram_addr]  <= 1'b1;
        end else if (a_sram_req) begin
            a_pipe0 <= cur;
        end
        a_pipe1 <= a_pipe0;
        b_pipe0 <= (b_sram_req && !b_sram_we) ? (32'hB0B0_0000 | 32'(b_sram_addr)) : 32'hDEAD_BEEF;
        b_pipe1 <= b_pipe0;
    end

    // Reference model for A: responses are queued in acceptance order, each
    // becoming visible Lat+1 cycles after acceptance; a read may be taken
    // while fewer than RspDepth reads are accepted but not yet popped.
    bit [31:0] ref_mem [16];
    bit        ref_wr  [16];

    always @(negedge clk) begin
        bit          exp_valid, exp_ready;
        logic [31:0] cur;
        if (!rst_a_n) begin
            q_a.delete();
            checkOutput("a_reset_ready", 32'(a_req_ready), 32'd1);
            checkOutput("a_reset_valid", 32'(a_rsp_valid), 32'd0);
        end else begin
            exp_valid = (q_a.size() > 0) && (q_a[0].avail <= cyc);
            exp_ready = a_req_we || (q_a.size() < 2);
            checkOutput("a_req_ready", 32'(a_req_ready), 32'(exp_ready));
            checkOutput("a_sram_req", 32'(a_sram_req), 32'(a_req_valid && exp_ready));
            if (a_req_valid) begin
                checkOutput("a_sram_ctl", {23'd0, a_sram_we, a_sram_addr, a_sram_be},
                            {23'd0, a_req_we, a_req_addr, a_req_be});
                checkOutput("a_sram_wdata", a_sram_wdata, a_req_wdata);
            end
            checkOutput("a_rsp_valid", 32'(a_rsp_valid), 32'(exp_valid));
            if (exp_valid) checkOutput("a_rsp_rdata", a_rsp_rdata, q_a[0].data);
            if (exp_valid && a_rsp_ready) void'(q_a.pop_front());
            if (a_req_valid && exp_ready) begin
                cur = ref_wr[a_req_addr] ? ref_mem[a_req_addr] : (32'hA5A5_0000 | 32'(a_req_addr));
                if (a_req_we) begin
                    for (int k = 0; k < 4; k++)
                        if (a_req_be[k]) cur[8*k +: 8] = a_req_wdata[8*k +: 8];
                    ref_mem[a_req_addr] = cur;
                    ref_wr[a_req_addr]  = 1'b1;
                end else begin
                    q_a.push_back('{data: cur, avail: cyc + Lat + 1});
                end
            end
        end
    end

    // Same model for B (RspDepth 3, read-only, data B0B0_00xx).
    always @(negedge clk) begin
        bit exp_valid, exp_ready;
        if (!rst_b_n) begin
            q_b.delete();
            checkOutput("b_reset_ready", 32'(b_req_ready), 32'd1);
            checkOutput("b_reset_valid", 32'(b_rsp_valid), 32'd0);
        end else begin
            exp_valid = (q_b.size() > 0) && (q_b[0].avail <= cyc);
            exp_ready = b_req_we || (q_b.size() < 3);
            checkOutput("b_req_ready", 32'(b_req_ready), 32'(exp_ready));
            checkOutput("b_rsp_valid", 32'(b_rsp_valid), 32'(exp_valid));
            if (exp_valid) checkOutput("b_rsp_rdata", b_rsp_rdata, q_b[0].data);
            if (exp_valid && b_rsp_ready) begin
                void'(q_b.pop_front());
                b_pops++;
            end
            if (b_req_valid && exp_ready && !b_req_we)
                q_b.push_back('{data: 32'hB0B0_0000 | 32'(b_req_addr), avail: cyc + Lat + 1});
        end
    end

    task automatic idleA(input int n, input bit rnd);
        repeat (n) begin
            if (rnd) a_rsp_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    // Drives one request on A and holds it until the DUT takes it.
    task automatic applyStimulus(input bit we, input logic [3:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input bit rnd);
        bit acc;
        int waited;
        a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr;
        a_req_wdata = wdata; a_req_be = be;
        waited = 0;
        if (rnd) a_rsp_ready = 1'($urandom_range(0, 1));
        do begin
            @(negedge clk); acc = a_req_ready;
            @(posedge clk); #1; waited++;
            if (!acc && rnd) a_rsp_ready = 1'($urandom_range(0, 1));
        end while (!acc && waited < 50);
        if (!acc) checkOutput("a_req_timeout", 32'd0, 32'd1);
        a_req_valid = 1'b0;
    endtask

    task automatic applyStimulusB(input logic [3:0] addr);
        bit acc;
        int waited;
        b_req_valid = 1'b1; b_req_addr = addr;
        waited = 0;
        do begin
            @(negedge clk); acc = b_req_ready;
            @(posedge clk); #1; waited++;
        end while (!acc && waited < 50);
        if (!acc) checkOutput("b_req_timeout", 32'd0, 32'd1);
        b_req_valid = 1'b0;
    endtask

    // Single read on an idle A with rsp ready: response exactly in cycle t+3, one cycle wide.
    task automatic readCheck(input logic [3:0] addr, input logic [31:0] exp);
        a_rsp_ready = 1'b1;
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = addr;
        @(negedge clk); checkOutput("rd_accept", 32'(a_req_ready), 32'd1);
        @(posedge clk); #1; a_req_valid = 1'b0;
        @(negedge clk); checkOutput("rd_t1_idle", 32'(a_rsp_valid), 32'd0);
        @(negedge clk); checkOutput("rd_t2_idle", 32'(a_rsp_valid), 32'd0);
        @(negedge clk); checkOutput("rd_t3_valid", 32'(a_rsp_valid), 32'd1);
        checkOutput("rd_t3_data", a_rsp_rdata, exp);
        @(negedge clk); checkOutput("rd_t4_idle", 32'(a_rsp_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int t0;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
        a_rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = 4'hF;
        b_rsp_ready = 1'b1;
        #2;
        checkOutput("init_ready", 32'(a_req_ready), 32'd1);
        checkOutput("init_valid", 32'(a_rsp_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1; rst_a_n = 1'b1; rst_b_n = 1'b1;
        idleA(2, 1'b0);

        readCheck(4'd5, 32'hA5A5_0005);

        // Fill A with two reads while rsp_ready is low, then a write and a third read.
        a_rsp_ready = 1'b0;
        applyStimulus(1'b0, 4'd1, 32'h0, 4'h0, 1'b0);
        applyStimulus(1'b0, 4'd2, 32'h0, 4'h0, 1'b0);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 4'd3;
        a_req_wdata = 32'h0000_1234; a_req_be = 4'b0011;
        @(negedge clk);
        checkOutput("write_while_full", {29'd0, a_req_ready, a_sram_req, a_sram_we}, 32'd7);
        @(posedge clk); #1;
        a_req_we = 1'b0; a_req_addr = 4'd3; a_req_be = 4'h0;
        repeat (4) begin
            @(negedge clk); checkOutput("read3_stalled", 32'(a_req_ready), 32'd0);
            @(posedge clk); #1;
        end
        a_rsp_ready = 1'b1;
        @(negedge clk); checkOutput("pop_cycle_no_credit", 32'(a_req_ready), 32'd0);
        @(posedge clk); #1; a_rsp_ready = 1'b0;
        @(negedge clk); checkOutput("credit_next_cycle", 32'(a_req_ready), 32'd1);
        @(posedge clk); #1; a_req_valid = 1'b0;
        a_rsp_ready = 1'b1;
        idleA(8, 1'b0);
        readCheck(4'd3, 32'hA5A5_1234);

        // Ten consecutive reads on the depth-3 instance with rsp_ready held.
        b_rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulusB(4'(i));
        repeat (10) @(posedge clk);
        #1; checkOutput("b_ten_responses", 32'(b_pops), 32'd10);

        // Reset B with one response queued and two reads in flight.
        b_rsp_ready = 1'b0;
        applyStimulusB(4'd7);
        applyStimulusB(4'd8);
        applyStimulusB(4'd9);
        #3; checkOutput("b_pre_reset_valid", 32'(b_rsp_valid), 32'd1);
        rst_b_n = 1'b0;
        #1; checkOutput("b_async_reset_valid", 32'(b_rsp_valid), 32'd0);
        checkOutput("b_async_reset_ready", 32'(b_req_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1; rst_b_n = 1'b1; b_rsp_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1; t0 = cyc;
        applyStimulusB(4'd1);
        applyStimulusB(4'd2);
        applyStimulusB(4'd3);
        checkOutput("b_full_credits_after_reset", 32'(cyc - t0), 32'd3);
        repeat (8) @(posedge clk);
        #1;

        // Random mixed traffic on A with random response backpressure.
        for (int i = 0; i < 400; i++) begin
            idleA($urandom_range(0, 2), 1'b1);
            applyStimulus($urandom_range(0, 9) < 3, 4'($urandom_range(0, 15)), $urandom,
                          4'($urandom_range(0, 15)), 1'b1);
        end
        a_rsp_ready = 1'b1;
        idleA(10, 1'b0);
        checkOutput("a_drained", 32'(q_a.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
